// File: rtl/rtp_result_collector.sv
// Collects per-ray hit results from NUM_CH RTP cores into one FIFO and tracks run length, ray count and completion.
// Define RTP_COLLECT_TIMEOUT_EN to add a stall watchdog that can move the run into the TIMEOUT state.
module rtp_result_collector #(
   parameter int NUM_CH     = 2,
   parameter int DATA_W     = 32,
   parameter int ID_W       = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 64,
   parameter int TIMEOUT    = 1048576,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH*DATA_W-1:0] ch_hitT,
   input  logic [NUM_CH*ID_W-1:0]   ch_ray_id,
   input  logic [NUM_CH-1:0]        ch_finish,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_hitT,
   output logic [ID_W-1:0]          out_ray_id,
   output logic [CH_W-1:0]          out_ch,
   output logic                     all_finish,
   output logic [CNT_W-1:0]         run_cycles,
   output logic [CNT_W-1:0]         ray_count,
   output logic                     overflow,
   output logic                     timeout,
   output logic [1:0]               state
);

   // Read port: out_valid depends only on FIFO occupancy, never on out_ready;
   // the head entry is consumed on any cycle where out_valid && out_ready.

   localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW_F  = AW + 1;
   localparam int ENT_W = CH_W + DATA_W + ID_W;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_DONE    = 2'd2,
      S_TIMEOUT = 2'd3
   } state_t;

   state_t                         state_q, state_d;
   logic [NUM_CH-1:0]              pend_v_q, pend_v_d;
   logic [NUM_CH-1:0][DATA_W-1:0]  pend_hit_q, pend_hit_d;
   logic [NUM_CH-1:0][ID_W-1:0]    pend_id_q, pend_id_d;
   logic [CH_W-1:0]                rr_q, rr_d;
   logic [NUM_CH-1:0]              fin_q, fin_d;
   logic [CNT_W-1:0]               run_q, run_d;
   logic [CNT_W-1:0]               ray_q, ray_d;
   logic                           ovf_q, ovf_d;
   logic [AW-1:0]                  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]                  rd_ptr_q, rd_ptr_d;
   logic [CW_F-1:0]                cnt_q, cnt_d;
   logic [ENT_W-1:0]               mem_q [FIFO_DEPTH];

   logic                           pop;
   logic                           can_write;
   logic                           grant_vld;
   logic [CH_W-1:0]                grant_idx;
   logic [NUM_CH-1:0]              load_vec;
   logic                           wd_expired;

   assign pop       = (cnt_q != '0) && out_ready;
   assign can_write = (cnt_q < CW_F'(FIFO_DEPTH)) || pop;

   // Round-robin: lowest offset from rr wins, so scan offsets high to low.
   always_comb begin
      int idx;
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = 0;
      if (state_q == S_RUN && !start && can_write) begin
         for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (pend_v_q[CH_W'(idx)]) begin
               grant_vld = 1'b1;
               grant_idx = CH_W'(idx);
            end
         end
      end
   end

   // A pending slot accepts a new result if it is empty or drains this cycle.
   always_comb begin
      load_vec = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         load_vec[i] = (state_q == S_RUN) && !start && ch_valid[i] &&
                       (!pend_v_q[i] || (grant_vld && grant_idx == CH_W'(i)));
      end
   end

   always_comb begin
      state_d    = state_q;
      pend_v_d   = pend_v_q;
      pend_hit_d = pend_hit_q;
      pend_id_d  = pend_id_q;
      rr_d       = rr_q;
      fin_d      = fin_q;
      run_d      = run_q;
      ray_d      = ray_q;
      ovf_d      = ovf_q;
      wr_ptr_d   = grant_vld ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d      = cnt_q + CW_F'(grant_vld) - CW_F'(pop);
      if (start) begin
         state_d    = S_RUN;
         pend_v_d   = '0;
         pend_hit_d = '0;
         pend_id_d  = '0;
         rr_d       = '0;
         fin_d      = '0;
         run_d      = '0;
         ray_d      = '0;
         ovf_d      = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         cnt_d      = '0;
      end else if (state_q == S_RUN) begin
         if (grant_vld) begin
            pend_v_d[grant_idx] = 1'b0;
            rr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (load_vec[i]) begin
               pend_v_d[i]   = 1'b1;
               pend_hit_d[i] = ch_hitT[i*DATA_W +: DATA_W];
               pend_id_d[i]  = ch_ray_id[i*ID_W +: ID_W];
               ray_d         = ray_d + CNT_W'(1);
            end else if (ch_valid[i]) begin
               ovf_d = 1'b1;
            end
         end
         fin_d = fin_q | ch_finish;
         run_d = run_q + CNT_W'(1);
         // Completion waits for pending slots to drain; the FIFO may still hold data.
         if ((&fin_d) && (pend_v_d == '0)) state_d = S_DONE;
         else if (wd_expired)              state_d = S_TIMEOUT;
      end
   end

`ifdef RTP_COLLECT_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_q, wd_d;

   assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

   always_comb begin
      wd_d = wd_q;
      if (start)                 wd_d = '0;
      else if (state_q == S_RUN) wd_d = (|load_vec) ? '0 : wd_q + WD_W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) wd_q <= '0;
      else       wd_q <= wd_d;
   end
`else
   assign wd_expired = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pend_v_q   <= '0;
         pend_hit_q <= '0;
         pend_id_q  <= '0;
         rr_q       <= '0;
         fin_q      <= '0;
         run_q      <= '0;
         ray_q      <= '0;
         ovf_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pend_v_q   <= pend_v_d;
         pend_hit_q <= pend_hit_d;
         pend_id_q  <= pend_id_d;
         rr_q       <= rr_d;
         fin_q      <= fin_d;
         run_q      <= run_d;
         ray_q      <= ray_d;
         ovf_q      <= ovf_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

   always_ff @(posedge clock) begin
      if (grant_vld) mem_q[wr_ptr_q] <= {grant_idx, pend_hit_q[grant_idx], pend_id_q[grant_idx]};
   end

   assign out_valid  = (cnt_q != '0);
   assign out_ch     = out_valid ? mem_q[rd_ptr_q][ENT_W-1 -: CH_W] : '0;
   assign out_hitT   = out_valid ? mem_q[rd_ptr_q][ID_W +: DATA_W] : '0;
   assign out_ray_id = out_valid ? mem_q[rd_ptr_q][ID_W-1:0] : '0;
   assign all_finish = (state_q == S_DONE);
   assign timeout    = (state_q == S_TIMEOUT);
   assign run_cycles = run_q;
   assign ray_count  = ray_q;
   assign overflow   = ovf_q;
   assign state      = state_q;

endmodule

// File: tb/tb_rtp_result_collector.sv
// Bench for rtp_result_collector: directed scenarios plus random traffic against a queue-based reference model.
module tb_rtp_result_collector;

   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int TMO   = 8;
`ifdef RTP_COLLECT_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic          clock, reset, start, out_ready;
   logic [N-1:0]  ch_valid, ch_finish;
   logic [N*32-1:0] ch_hitT, ch_ray_id;
   logic          out_valid, all_finish, overflow, timeout;
   logic [31:0]   out_hitT, out_ray_id;
   logic [1:0]    out_ch, state;
   logic [63:0]   run_cycles, ray_count;

   rtp_result_collector #(
      .NUM_CH(N), .DATA_W(32), .ID_W(32), .FIFO_DEPTH(DEPTH), .CNT_W(64), .TIMEOUT(TMO)
   ) dut (
      .clock(clock), .reset(reset), .start(start),
      .ch_valid(ch_valid), .ch_hitT(ch_hitT), .ch_ray_id(ch_ray_id), .ch_finish(ch_finish),
      .out_valid(out_valid), .out_ready(out_ready), .out_hitT(out_hitT), .out_ray_id(out_ray_id),
      .out_ch(out_ch), .all_finish(all_finish), .run_cycles(run_cycles), .ray_count(ray_count),
      .overflow(overflow), .timeout(timeout), .state(state)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: pending slots, FIFO as a queue, plain counters.
   typedef struct {
      logic [31:0] h;
      logic [31:0] id;
      int          ch;
   } ent_t;

   int               m_state;
   bit [N-1:0]       m_pv;
   logic [31:0]      m_ph [N];
   logic [31:0]      m_pi [N];
   ent_t             m_fifo [$];
   int               m_rr;
   logic [N-1:0]     m_fin;
   logic [63:0]      m_run, m_rays;
   bit               m_ovf;
   int               m_wd;

   task automatic model_clear();
      m_pv = '0;
      m_fifo.delete();
      m_rr = 0;
      m_fin = '0;
      m_run = 0;
      m_rays = 0;
      m_ovf = 1'b0;
      m_wd = 0;
   endtask

   task automatic model_step();
      bit   pop, can_wr, acc;
      int   g, idx;
      ent_t e;
      if (reset) begin
         model_clear();
         m_state = 0;
         return;
      end
      if (start) begin
         model_clear();
         m_state = 1;
         return;
      end
      pop    = (m_fifo.size() > 0) && out_ready;
      can_wr = (m_fifo.size() < DEPTH) || pop;
      if (pop) void'(m_fifo.pop_front());
      if (m_state != 1) return;
      g = -1;
      if (can_wr) begin
         for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (g < 0 && m_pv[idx]) g = idx;
         end
      end
      if (g >= 0) begin
         e.h  = m_ph[g];
         e.id = m_pi[g];
         e.ch = g;
         m_fifo.push_back(e);
         m_pv[g] = 1'b0;
         m_rr = (g + 1) % N;
      end
      acc = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (ch_valid[i]) begin
            if (!m_pv[i]) begin
               m_pv[i] = 1'b1;
               m_ph[i] = ch_hitT[i*32 +: 32];
               m_pi[i] = ch_ray_id[i*32 +: 32];
               m_rays  = m_rays + 1;
               acc     = 1'b1;
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
      m_fin = m_fin | ch_finish;
      m_run = m_run + 1;
      if (m_fin == {N{1'b1}} && m_pv == '0) m_state = 2;
      else if (TMO_EN && m_wd == TMO - 1)   m_state = 3;
      m_wd = acc ? 0 : m_wd + 1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("state", 64'(state), 64'(m_state));
      chk("out_valid", 64'(out_valid), 64'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) begin
         chk("out_hitT", 64'(out_hitT), 64'(m_fifo[0].h));
         chk("out_ray_id", 64'(out_ray_id), 64'(m_fifo[0].id));
         chk("out_ch", 64'(out_ch), 64'(m_fifo[0].ch));
      end
      chk("ray_count", ray_count, m_rays);
      chk("run_cycles", run_cycles, m_run);
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("all_finish", 64'(all_finish), 64'(m_state == 2));
      chk("timeout", 64'(timeout), 64'(m_state == 3));
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
      check_all();
   endtask

   task automatic set_ch(input int i, input logic [31:0] h, input logic [31:0] id);
      ch_hitT[i*32 +: 32]   = h;
      ch_ray_id[i*32 +: 32] = id;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; out_ready = 1'b0;
      ch_valid = '0; ch_finish = '0; ch_hitT = '0; ch_ray_id = '0;
      m_state = 0;
      model_clear();
      tick();
      tick();
      reset = 1'b0;
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_ray_count", ray_count, 64'd0);
      chk("rst_run_cycles", run_cycles, 64'd0);

      // Single source channel, three results back to back.
      start = 1'b1; tick(); start = 1'b0;
      chk("start_state", 64'(state), 64'd1);
      chk("start_run0", run_cycles, 64'd0);
      out_ready = 1'b1;
      ch_valid = 4'b0001; set_ch(0, 32'h3F800000, 32'd5); tick();
      chk("sc_ray1", ray_count, 64'd1);
      chk("sc_lat_not_yet", 64'(out_valid), 64'd0);
      set_ch(0, 32'h3F800000, 32'd6); tick();
      chk("sc_out5", 64'(out_ray_id), 64'd5);
      chk("sc_hit", 64'(out_hitT), 64'h3F800000);
      set_ch(0, 32'h3F800000, 32'd7); tick();
      chk("sc_out6", 64'(out_ray_id), 64'd6);
      ch_valid = '0; tick();
      chk("sc_out7", 64'(out_ray_id), 64'd7);
      tick();
      chk("sc_empty", 64'(out_valid), 64'd0);
      chk("sc_ray3", ray_count, 64'd3);

      // All channels strobe together: round-robin order 0..3.
      start = 1'b1; tick(); start = 1'b0;
      ch_valid = 4'b1111;
      for (int i = 0; i < N; i++) set_ch(i, $urandom, 32'(10 + i));
      tick();
      ch_valid = '0;
      for (int i = 0; i < N; i++) begin
         tick();
         chk("rr_out_ch", 64'(out_ch), 64'(i));
      end
      chk("rr_ray4", ray_count, 64'd4);
      chk("rr_no_ovf", 64'(overflow), 64'd0);

      // Backpressure: 4 in FIFO, 1 pending, 2 dropped.
      start = 1'b1; tick(); start = 1'b0;
      out_ready = 1'b0;
      ch_valid = 4'b0001;
      for (int k = 0; k < 7; k++) begin
         set_ch(0, $urandom, 32'(20 + k));
         tick();
      end
      ch_valid = '0; tick();
      chk("bp_ray5", ray_count, 64'd5);
      chk("bp_ovf", 64'(overflow), 64'd1);
      chk("bp_head", 64'(out_ray_id), 64'd20);
      out_ready = 1'b1;
      for (int k = 0; k < 7; k++) tick();

      // Finish bits at cycles 10 and 20; ch2 keeps the watchdog fed.
      start = 1'b1; tick(); start = 1'b0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         ch_valid  = (cyc % 3 == 0) ? 4'b0100 : 4'b0000;
         set_ch(2, $urandom, 32'(100 + cyc));
         ch_finish = (cyc == 10) ? 4'b0011 : (cyc == 20) ? 4'b1100 : 4'b0000;
         tick();
         if (cyc == 19) chk("fin_early", 64'(all_finish), 64'd0);
      end
      ch_valid = '0; ch_finish = '0;
      chk("fin_done", 64'(all_finish), 64'd1);
      chk("fin_state", 64'(state), 64'd2);
      chk("fin_run20", run_cycles, 64'd20);
      ch_valid = 4'b0001; tick(); ch_valid = '0; tick();
      chk("fin_frozen", run_cycles, 64'd20);
      chk("fin_ray6", ray_count, 64'd6);

      // Idle run: watchdog fires after 8 RUN cycles when built in.
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 7) chk("wd_still_run", 64'(state), 64'd1);
      end
      chk("wd_state", 64'(state), TMO_EN ? 64'd3 : 64'd1);
      chk("wd_timeout", 64'(timeout), TMO_EN ? 64'd1 : 64'd0);

      // Reset mid-run with three buffered results.
      start = 1'b1; tick(); start = 1'b0;
      out_ready = 1'b0; ch_valid = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         set_ch(0, $urandom, 32'(200 + k));
         tick();
      end
      ch_valid = '0; tick(); tick();
      chk("mr_filled", 64'(out_valid), 64'd1);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("mr_out_valid", 64'(out_valid), 64'd0);
      chk("mr_ray0", ray_count, 64'd0);
      chk("mr_state", 64'(state), 64'd0);

      // Random traffic.
      for (int n = 0; n < 2500; n++) begin
         reset     = ($urandom_range(0, 499) == 0);
         start     = ($urandom_range(0, 99) == 0) || (m_state != 1 && $urandom_range(0, 9) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         for (int i = 0; i < N; i++) begin
            ch_valid[i]  = ($urandom_range(0, 99) < 35);
            ch_finish[i] = ($urandom_range(0, 59) == 0);
            set_ch(i, $urandom, $urandom);
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
